// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder and the CPU that talks to it.
`ifndef ARCH_SIZE
`define ARCH_SIZE 15
`endif

package mem_responder_pkg;
  localparam int WORD_W = `ARCH_SIZE + 1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // CPU opcodes; HALT sits in the top nibble so it survives any ARCH_SIZE >= 3.
  localparam word_t NOOP = '0;
  localparam word_t HALT = {4'hF, {(WORD_W-4){1'b0}}};

  // Captured request; bit 0 of the byte address is dropped at capture.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [WORD_W-2:0] idx;
    word_t             wdata;
  } req_t;
endpackage

// File: rtl/mem_responder_if.sv
// Four-phase request/ready memory bus between a requester and mem_responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  word_t mem_address;
  logic  mem_read;
  logic  mem_write;
  word_t mem_wdata;
  word_t mem_value;
  logic  mem_ready;
  logic  mem_error;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata,
    input  mem_value, mem_ready, mem_error
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata,
    output mem_value, mem_ready, mem_error
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  word_t         wdata_i,
  output word_t         rdata_o
);
  word_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_responder.sv
// Four-phase memory responder: captures a request, waits LATENCY cycles,
// performs the access, then holds the result until the requester lets go.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  mem_responder_if.slave mem
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  word_t      value_q, value_d;
  logic       ready_q, ready_d;
  logic       error_q, error_d;

  logic  req_seen, legal, mem_we;
  word_t rdata;
  logic  unused_addr_lsb;

  assign req_seen        = mem.mem_read | mem.mem_write;
  assign unused_addr_lsb = mem.mem_address[0];
  // Out-of-range or simultaneous read+write never touches storage.
  assign legal = (int'(req_q.idx) < DEPTH) && !(req_q.rd && req_q.wr);

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem_array (
    .clock   (clock),
    .we_i    (mem_we),
    .addr_i  (req_q.idx[AW-1:0]),
    .wdata_i (req_q.wdata),
    .rdata_o (rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_seen)     state_d = WAIT;
      WAIT:    if (cnt_q == '0)  state_d = DONE;
      DONE:    if (!req_seen)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    value_d = value_q;
    ready_d = ready_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_seen) begin
          req_d.rd    = mem.mem_read;
          req_d.wr    = mem.mem_write;
          req_d.idx   = mem.mem_address[WORD_W-1:1];
          req_d.wdata = mem.mem_wdata;
          cnt_d       = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          error_d = !legal;
          mem_we  = legal && req_q.wr;
          if (!legal)        value_d = '0;
          else if (req_q.wr) value_d = req_q.wdata;
          else               value_d = rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!req_seen) begin
          ready_d = 1'b0;
          value_d = '0;
          error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      req_q   <= '0;
      value_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      value_q <= value_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign mem.mem_value = value_q;
  assign mem.mem_ready = ready_q;
  assign mem.mem_error = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: table of single transactions on a LATENCY=2 responder,
// plus hand-written reset, hold and CPU-fetch sequences on LATENCY 1/2/15.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int TMO = 40;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic  rd_r [3];
  logic  wr_r [3];
  word_t addr_r [3];
  word_t wdata_r [3];
  logic  rdy_w [3];
  logic  err_w [3];
  word_t val_w [3];

  mem_responder_if if0 ();
  mem_responder_if if1 ();
  mem_responder_if if2 ();

  assign if0.mem_read = rd_r[0]; assign if0.mem_write = wr_r[0];
  assign if0.mem_address = addr_r[0]; assign if0.mem_wdata = wdata_r[0];
  assign rdy_w[0] = if0.mem_ready; assign err_w[0] = if0.mem_error; assign val_w[0] = if0.mem_value;
  assign if1.mem_read = rd_r[1]; assign if1.mem_write = wr_r[1];
  assign if1.mem_address = addr_r[1]; assign if1.mem_wdata = wdata_r[1];
  assign rdy_w[1] = if1.mem_ready; assign err_w[1] = if1.mem_error; assign val_w[1] = if1.mem_value;
  assign if2.mem_read = rd_r[2]; assign if2.mem_write = wr_r[2];
  assign if2.mem_address = addr_r[2]; assign if2.mem_wdata = wdata_r[2];
  assign rdy_w[2] = if2.mem_ready; assign err_w[2] = if2.mem_error; assign val_w[2] = if2.mem_value;

  mem_responder #(.DEPTH(256), .LATENCY(2))  u_l2  (.clock(clock), .reset_n(reset_n), .mem(if0.slave));
  mem_responder #(.DEPTH(256), .LATENCY(1))  u_l1  (.clock(clock), .reset_n(reset_n), .mem(if1.slave));
  mem_responder #(.DEPTH(256), .LATENCY(15)) u_l15 (.clock(clock), .reset_n(reset_n), .mem(if2.slave));

  typedef struct {
    logic  r;
    logic  w;
    word_t a;
    word_t wd;
    word_t ev;
    logic  ee;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called just after the capture edge; counts edges until mem_ready rises.
  task automatic wait_ready(input int d, output int lat);
    lat = 0;
    while (!rdy_w[d] && lat < TMO) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!rdy_w[d]) begin
      checks++; failures++;
      $display("FAIL timeout_dut%0d: got ready=0 want ready=1 within %0d cycles", d, TMO);
    end
  endtask

  // Request must already be driven; the next posedge is the capture edge.
  task automatic run_req(input int d, output word_t val, output logic err,
                         output int lat, output int total);
    int c0;
    @(posedge clock); #1;
    c0 = cyc;
    wait_ready(d, lat);
    val = val_w[d];
    err = err_w[d];
    @(negedge clock); rd_r[d] = 1'b0; wr_r[d] = 1'b0;
    @(posedge clock); #1;
    total = cyc - c0 + 1;
    chk($sformatf("release_dut%0d", d), rdy_w[d], 0);
  endtask

  task automatic txn(input int d, input logic r, input logic w, input word_t a, input word_t wd,
                     output word_t val, output logic err, output int lat, output int total);
    @(negedge clock);
    rd_r[d] = r; wr_r[d] = w; addr_r[d] = a; wdata_r[d] = wd;
    run_req(d, val, err, lat, total);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t v;
    logic  e;
    int    lat, tot, lmax, pc, dd;
    word_t exp_op;

    for (int i = 0; i < 3; i++) begin
      rd_r[i] = 1'b0; wr_r[i] = 1'b0; addr_r[i] = '0; wdata_r[i] = '0;
    end

    vecs[0]  = '{1'b0, 1'b1, 16'h0004, 16'h1234, 16'h1234, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0200, 16'h5555, 16'h0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h01FE, 16'h00FF, 16'h00FF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h01FF, 16'h0000, 16'h00FF, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'h0008, 16'h0008, 16'h0008, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0};

    #2 reset_n = 1'b0;
    #6;
    chk("reset_ready", rdy_w[0], 0);
    chk("reset_value", val_w[0], 0);
    chk("reset_error", err_w[0], 0);
    @(negedge clock); reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, v, e, lat, tot);
      chk($sformatf("vec%0d_value", i), v, vecs[i].ev);
      chk($sformatf("vec%0d_error", i), e, vecs[i].ee);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_cycles", i), tot, 4);
    end

    // Read and write together, request held 5 extra cycles after ready.
    @(negedge clock);
    rd_r[0] = 1'b1; wr_r[0] = 1'b1; addr_r[0] = 16'h0004; wdata_r[0] = 16'hFFFF;
    @(posedge clock); #1;
    wait_ready(0, lat);
    chk("both_latency", lat, 2);
    chk("both_value", val_w[0], 0);
    chk("both_error", err_w[0], 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      chk($sformatf("both_hold%0d", k), rdy_w[0], 1);
    end
    @(negedge clock); rd_r[0] = 1'b0; wr_r[0] = 1'b0;
    @(posedge clock); #1;
    chk("both_release", rdy_w[0], 0);
    txn(0, 1'b1, 1'b0, 16'h0004, 16'h0000, v, e, lat, tot);
    chk("both_word_kept", v, 16'h1234);

    // Request/address changes after capture are ignored.
    @(negedge clock);
    rd_r[0] = 1'b1; addr_r[0] = 16'h0004;
    @(posedge clock); #1;
    @(negedge clock); wr_r[0] = 1'b1; addr_r[0] = 16'h0000; wdata_r[0] = 16'h7777;
    wait_ready(0, lat);
    chk("late_change_value", val_w[0], 16'h1234);
    chk("late_change_error", err_w[0], 0);
    @(negedge clock); rd_r[0] = 1'b0; wr_r[0] = 1'b0;
    @(posedge clock); #1;
    txn(0, 1'b1, 1'b0, 16'h0000, 16'h0000, v, e, lat, tot);
    chk("late_change_word0", v, 16'hA5A5);

    // Reset during WAIT of a write aborts it.
    @(negedge clock);
    wr_r[0] = 1'b1; addr_r[0] = 16'h0008; wdata_r[0] = 16'hBEEF;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_ready", rdy_w[0], 0);
    repeat (3) @(posedge clock);
    @(negedge clock); wr_r[0] = 1'b0; reset_n = 1'b1;
    txn(0, 1'b1, 1'b0, 16'h0008, 16'h0000, v, e, lat, tot);
    chk("abort_old_value", v, 16'h0008);
    chk("abort_error", e, 0);

    // Reset while DONE clears outputs without a clock edge.
    @(negedge clock);
    rd_r[0] = 1'b1; addr_r[0] = 16'h0004;
    @(posedge clock); #1;
    wait_ready(0, lat);
    chk("done_value", val_w[0], 16'h1234);
    #2 reset_n = 1'b0;
    #1;
    chk("async_ready", rdy_w[0], 0);
    chk("async_value", val_w[0], 0);
    chk("async_error", err_w[0], 0);
    @(negedge clock); rd_r[0] = 1'b0;
    // First edge after reset release captures.
    @(negedge clock);
    reset_n = 1'b1; rd_r[0] = 1'b1; addr_r[0] = 16'h0008;
    run_req(0, v, e, lat, tot);
    chk("post_reset_value", v, 16'h0008);
    chk("post_reset_latency", lat, 2);

    // CPU fetch model on LATENCY=1 and LATENCY=15.
    for (int s = 0; s < 2; s++) begin
      dd   = (s == 0) ? 1 : 2;
      lmax = (s == 0) ? 1 : 15;
      txn(dd, 1'b0, 1'b1, 16'h0000, NOOP, v, e, lat, tot);
      txn(dd, 1'b0, 1'b1, 16'h0002, NOOP, v, e, lat, tot);
      txn(dd, 1'b0, 1'b1, 16'h0004, HALT, v, e, lat, tot);
      chk($sformatf("cpu%0d_load_error", lmax), e, 0);
      pc = 0;
      do begin
        txn(dd, 1'b1, 1'b0, word_t'(pc), '0, v, e, lat, tot);
        exp_op = (pc == 4) ? HALT : NOOP;
        chk($sformatf("cpu%0d_op_pc%0d", lmax, pc), v, exp_op);
        chk($sformatf("cpu%0d_lat_pc%0d", lmax, pc), lat, lmax);
        chk($sformatf("cpu%0d_cycles_pc%0d", lmax, pc), tot, lmax + 2);
        chk($sformatf("cpu%0d_err_pc%0d", lmax, pc), e, 0);
        pc += 2;
      end while (v != HALT && pc <= 4);
      chk($sformatf("cpu%0d_halt_pc", lmax), pc, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
